// File: rtl/regwb_arbiter.sv
// regwb_arbiter
//   Shares one register-file write port between two writeback sources.
//   req0 is the in-order pipeline writeback, req1 is the long-latency unit
//   (divider / load return). Each source has its own DEPTH-entry FIFO. A
//   priority arbiter drains one entry per cycle into the registered write
//   port. FIFO0 normally wins. FIFO1 is forced to win when it is full, or when
//   its head has lost STARVE_LIMIT times in a row. A per-register pending
//   bitmap lets decode stall on writes that are still queued.
//
//   Optional feature: define REGWB_STATS_EN to add a req0 stall counter
//   (stall_cnt output, stats_clr input).
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   req0_valid/ready    pipeline writeback handshake
//   req0_addr/data      destination register and write data
//   req1_valid/ready    long-latency writeback handshake
//   req1_addr/data      destination register and write data
//   we/waddr/wdata      registered register-file write port
//   pending             bit r set while any queued or outgoing write targets r
//   busy                any FIFO non-empty or we=1
//   stall_cnt           (REGWB_STATS_EN) cycles with req0_valid & !req0_ready
//   stats_clr           (REGWB_STATS_EN) synchronous clear of stall_cnt
//
// Handshake: a request transfers at a rising edge when valid & ready are both
// 1. ready = FIFO not full. It does not depend on valid. It is 0 during reset
// and during the first cycle after release. Address/data only need to be
// stable in the transfer cycle. Writes to register 0 are accepted, then
// dropped: they are never queued and never set pending.

module regwb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [ADDR_W-1:0]      req0_addr,
  input  logic [DATA_W-1:0]      req0_data,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [ADDR_W-1:0]      req1_addr,
  input  logic [DATA_W-1:0]      req1_data,
  output logic                   we,
  output logic [ADDR_W-1:0]      waddr,
  output logic [DATA_W-1:0]      wdata,
  output logic [(1<<ADDR_W)-1:0] pending,
`ifdef REGWB_STATS_EN
  input  logic                   stats_clr,
  output logic [31:0]            stall_cnt,
`endif
  output logic                   busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Per-requester FIFO state. Index 0 = pipeline, index 1 = long-latency.
  // Each pointer carries an extra wrap bit, so equal pointers mean empty and
  // pointers differing only in the wrap bit mean full.
  logic [PW:0]        wr_ptr [2];
  logic [PW:0]        rd_ptr [2];
  logic [ADDR_W-1:0]  q_addr [2][DEPTH];
  logic [DATA_W-1:0]  q_data [2][DEPTH];
  logic [DEPTH-1:0]   q_vld  [2];
  logic [DEPTH-1:0]   vld_nxt[2];

  logic [ADDR_W-1:0]  in_addr  [2];
  logic [DATA_W-1:0]  in_data  [2];
  logic [ADDR_W-1:0]  head_addr[2];
  logic [DATA_W-1:0]  head_data[2];

  logic [1:0]         in_valid;
  logic [1:0]         full;
  logic [1:0]         empty;
  logic [1:0]         rdy;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic               sel;

  // rdy_en holds ready low for the first cycle after reset release.
  logic               rdy_en;
  logic [SW-1:0]      starve_cnt;
  logic [SW-1:0]      starve_nxt;

  assign in_valid = {req1_valid, req0_valid};

  always_comb begin
    in_addr[0] = req0_addr;
    in_addr[1] = req1_addr;
    in_data[0] = req0_data;
    in_data[1] = req1_data;
  end

  // FIFO status, heads, push qualification
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      empty[q]     = (wr_ptr[q] == rd_ptr[q]);
      full[q]      = (wr_ptr[q][PW] != rd_ptr[q][PW]) &&
                     (wr_ptr[q][PW-1:0] == rd_ptr[q][PW-1:0]);
      rdy[q]       = rdy_en & ~full[q];
      push[q]      = in_valid[q] & rdy[q] & (in_addr[q] != '0);
      head_addr[q] = q_addr[q][rd_ptr[q][PW-1:0]];
      head_data[q] = q_data[q][rd_ptr[q][PW-1:0]];
    end
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];

  // Arbitration. FIFO0 has priority. A full FIFO1, or a FIFO1 head that has
  // already lost STARVE_LIMIT times, takes the slot instead.
  always_comb begin
    pop = 2'b00;
    if (!empty[0] && !empty[1]) begin
      if ((starve_cnt == STARVE_MAX) || full[1]) pop[1] = 1'b1;
      else                                      pop[0] = 1'b1;
    end else if (!empty[0]) begin
      pop[0] = 1'b1;
    end else if (!empty[1]) begin
      pop[1] = 1'b1;
    end
    sel = pop[1];
  end

  // Starvation counter: counts consecutive losses of a waiting FIFO1 head.
  always_comb begin
    starve_nxt = starve_cnt;
    if (empty[1] || pop[1])          starve_nxt = '0;
    else if (starve_cnt != STARVE_MAX) starve_nxt = starve_cnt + SW'(1);
  end

  // Slot-valid bits mirror FIFO occupancy, so pending is a plain decode.
  // A pop never hits the slot being pushed: a push needs the FIFO not full,
  // and a pop needs it not empty.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      vld_nxt[q] = q_vld[q];
      if (pop[q])  vld_nxt[q][rd_ptr[q][PW-1:0]] = 1'b0;
      if (push[q]) vld_nxt[q][wr_ptr[q][PW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en     <= 1'b0;
      starve_cnt <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      for (int q = 0; q < 2; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        q_vld[q]  <= '0;
      end
    end else begin
      rdy_en     <= 1'b1;
      starve_cnt <= starve_nxt;
      for (int q = 0; q < 2; q++) begin
        if (push[q]) wr_ptr[q] <= wr_ptr[q] + (PW+1)'(1);
        if (pop[q])  rd_ptr[q] <= rd_ptr[q] + (PW+1)'(1);
        q_vld[q] <= vld_nxt[q];
      end
      if (|pop) begin
        we    <= 1'b1;
        waddr <= head_addr[sel];
        wdata <= head_data[sel];
      end else begin
        // waddr/wdata keep their last value when idle.
        we <= 1'b0;
      end
    end
  end

  // Entry storage does not need a reset, because q_vld and the pointers
  // decide which entries are live.
  always_ff @(posedge clk) begin
    for (int q = 0; q < 2; q++) begin
      if (push[q]) begin
        q_addr[q][wr_ptr[q][PW-1:0]] <= in_addr[q];
        q_data[q][wr_ptr[q][PW-1:0]] <= in_data[q];
      end
    end
  end

  // pending: every live FIFO entry plus the write in the output register.
  always_comb begin
    pending = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[q][i]) pending[q_addr[q][i]] = 1'b1;
      end
    end
    if (we) pending[waddr] = 1'b1;
  end

  assign busy = ~empty[0] | ~empty[1] | we;

`ifdef REGWB_STATS_EN
  // Counts cycles where the pipeline wants to write back but FIFO0 is full.
  // A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           stall_cnt <= '0;
    else if (stats_clr)                 stall_cnt <= '0;
    else if (req0_valid && !req0_ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;

  localparam int DEPTH        = 2;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int EW           = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid = 1'b0;
  logic [ADDR_W-1:0] req0_addr  = '0;
  logic [DATA_W-1:0] req0_data  = '0;
  logic              req1_valid = 1'b0;
  logic [ADDR_W-1:0] req1_addr  = '0;
  logic [DATA_W-1:0] req1_data  = '0;
  logic              req0_ready, req1_ready, we, busy;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [31:0]       pending;
`ifdef REGWB_STATS_EN
  logic              stats_clr = 1'b0;
  logic [31:0]       stall_cnt;
`endif

  regwb_arbiter #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .we(we), .waddr(waddr), .wdata(wdata), .pending(pending),
`ifdef REGWB_STATS_EN
    .stats_clr(stats_clr), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Queues hold {addr,data} in arrival order. Grants follow the rules as
  // written: FIFO0 first, unless FIFO1 is full or has lost STARVE_LIMIT times.
  logic [EW-1:0]     m_q0[$];
  logic [EW-1:0]     m_q1[$];
  logic              m_started = 1'b0;
  int                m_starve  = 0;
  logic              m_we      = 1'b0;
  logic [ADDR_W-1:0] m_waddr   = '0;
  logic [DATA_W-1:0] m_wdata   = '0;
  logic [31:0]       m_stall   = '0;
  logic              m_r0, m_r1, m_pick1;
  logic [EW-1:0]     m_ent;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q0.delete();
      m_q1.delete();
      m_started = 1'b0;
      m_starve  = 0;
      m_we      = 1'b0;
      m_waddr   = '0;
      m_wdata   = '0;
      m_stall   = '0;
    end else begin
      m_r0 = m_started && (m_q0.size() < DEPTH);
      m_r1 = m_started && (m_q1.size() < DEPTH);
      if (m_q0.size() > 0 && m_q1.size() > 0)
        m_pick1 = (m_starve == STARVE_LIMIT) || (m_q1.size() == DEPTH);
      else
        m_pick1 = (m_q1.size() > 0);
      if (m_q0.size() > 0 || m_q1.size() > 0) begin
        m_ent   = m_pick1 ? m_q1.pop_front() : m_q0.pop_front();
        m_we    = 1'b1;
        m_waddr = m_ent[EW-1:DATA_W];
        m_wdata = m_ent[DATA_W-1:0];
      end else begin
        m_we = 1'b0;
      end
      // The loser count only matters while FIFO1 is still waiting after this
      // grant. After the pop, m_q1.size() reflects that.
      if (m_pick1 || m_q1.size() == 0) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (req0_valid && m_r0 && req0_addr != '0) m_q0.push_back({req0_addr, req0_data});
      if (req1_valid && m_r1 && req1_addr != '0) m_q1.push_back({req1_addr, req1_data});
`ifdef REGWB_STATS_EN
      if (stats_clr)                 m_stall = '0;
      else if (req0_valid && !m_r0)  m_stall = m_stall + 32'd1;
`endif
      m_started = 1'b1;
    end
  end

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    foreach (m_q0[i]) p[m_q0[i][EW-1:DATA_W]] = 1'b1;
    foreach (m_q1[i]) p[m_q1[i][EW-1:DATA_W]] = 1'b1;
    if (m_we) p[m_waddr] = 1'b1;
    return p;
  endfunction

  // Per-cycle compare against the model, plus a log of issued write addresses
  logic [ADDR_W-1:0] wr_log[$];

  always @(negedge clk) begin
    chk("we",      we,      m_we);
    chk("waddr",   waddr,   m_waddr);
    chk("wdata",   wdata,   m_wdata);
    chk("pending", pending, exp_pending());
    chk("busy",    busy,    (m_q0.size() > 0) || (m_q1.size() > 0) || m_we);
    chk("ready0",  req0_ready, m_started && (m_q0.size() < DEPTH));
    chk("ready1",  req1_ready, m_started && (m_q1.size() < DEPTH));
`ifdef REGWB_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (we) wr_log.push_back(waddr);
  end

  // ---------------- driver ----------------
  // Inputs change at negedge+1, well away from the active edge.
  task automatic cyc(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                     input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [ADDR_W-1:0] exp_seq[6];

  initial begin
    @(negedge clk); #1;
    idle(2);
    // reset / idle
    chk("rst_we",      we, 1'b0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_ready0",  req0_ready, 1'b0);
    chk("rst_ready1",  req1_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("rel_ready0_before_edge", req0_ready, 1'b0);
    idle(1);
    chk("rel_ready0", req0_ready, 1'b1);
    chk("rel_ready1", req1_ready, 1'b1);

    // single write: pending at N, write at N+1, clear at N+2
    cyc(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0);
    chk("sw_pending_n",  pending, 32'h0000_0020);
    chk("sw_we_n",       we, 1'b0);
    idle(1);
    chk("sw_we_n1",      we, 1'b1);
    chk("sw_waddr_n1",   waddr, 5'd5);
    chk("sw_wdata_n1",   wdata, 32'h1234_5678);
    chk("sw_pending_n1", pending, 32'h0000_0020);
    idle(1);
    chk("sw_pending_n2", pending, 32'h0);
    chk("sw_we_n2",      we, 1'b0);

    // zero address is accepted, then dropped
    chk("z_ready1", req1_ready, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("z_pending", pending, 32'h0);
    chk("z_busy",    busy, 1'b0);
    idle(1);
    chk("z_we",      we, 1'b0);
    idle(1);

    // starvation: req0 streams, one req1 entry waits for 3 losses
    wr_log.delete();
    cyc(1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd7, 32'hB000_0007);
    cyc(1'b1, 5'd2, 32'hA000_0002, 1'b0, '0, '0);
    cyc(1'b1, 5'd3, 32'hA000_0003, 1'b0, '0, '0);
    cyc(1'b1, 5'd4, 32'hA000_0004, 1'b0, '0, '0);
    cyc(1'b1, 5'd5, 32'hA000_0005, 1'b0, '0, '0);
    chk("st_ready0_full", req0_ready, 1'b0);
    chk("st_waddr_7",     waddr, 5'd7);
    chk("st_wdata_7",     wdata, 32'hB000_0007);
    cyc(1'b1, 5'd6, 32'hA000_0006, 1'b0, '0, '0);   // refused: FIFO0 full
`ifdef REGWB_STATS_EN
    chk("stat_one", stall_cnt, 32'd1);
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    chk("stat_clr", stall_cnt, 32'd0);
`endif
    idle(6);
    exp_seq = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd5};
    chk("st_log_len", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++)
      chk("st_log", wr_log[i], exp_seq[i]);

    // FIFO1 full forces the next grant and drops its ready
    cyc(1'b1, 5'd8,  32'hC000_0008, 1'b1, 5'd9,  32'hD000_0009);
    cyc(1'b1, 5'd10, 32'hC000_000A, 1'b1, 5'd11, 32'hD000_000B);
    chk("bp_ready1_low", req1_ready, 1'b0);
    chk("bp_waddr_8",    waddr, 5'd8);
    idle(1);
    chk("bp_waddr_9",    waddr, 5'd9);
    chk("bp_ready1_back", req1_ready, 1'b1);
    idle(5);

    // async reset mid-stream
    cyc(1'b1, 5'd12, 32'h1, 1'b1, 5'd13, 32'h2);
    cyc(1'b1, 5'd14, 32'h3, 1'b1, 5'd15, 32'h4);
    cyc(1'b1, 5'd16, 32'h5, 1'b1, 5'd17, 32'h6);
    chk("ar_busy_before", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_we",      we, 1'b0);
    chk("ar_pending", pending, 32'h0);
    chk("ar_busy",    busy, 1'b0);
    chk("ar_ready0",  req0_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wr_log.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    idle(6);
    chk("ar_no_stale", wr_log.size(), 0);

    // random drain mix for the per-cycle compare
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
